// File: rtl/noc_pkg.sv
// Shared definitions for the NoC client: page-id width, response field layout
// and the fetch FSM state encoding.
package noc_pkg;
  localparam int PAGE_ID_W = 6;
  localparam logic [PAGE_ID_W-1:0] NO_REQ = 6'd0;
  localparam int RESP_ID_LSB  = 0;
  localparam int RESP_ID_MSB  = PAGE_ID_W - 1;
  localparam int RESP_VAL_LSB = PAGE_ID_W;
  localparam int TABLE_N      = 16;
  localparam int N_PAGES      = 1 << PAGE_ID_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/noc_client_if.sv
// Network-side port bundle of the client: request/response path and the
// query/reply path that serves the local page table.
interface noc_client_if import noc_pkg::*; #(
  parameter int DATA_W = 16
);
  logic [PAGE_ID_W-1:0]        request;
  logic [DATA_W+PAGE_ID_W-1:0] response;
  logic                        response_valid;
  logic [PAGE_ID_W-1:0]        query_id;
  logic [DATA_W-1:0]           reply;

  modport master (
    output request,
    input  response,
    input  response_valid,
    input  query_id,
    output reply
  );

  modport slave (
    input  request,
    output response,
    output response_valid,
    output query_id,
    input  reply
  );
endinterface

// File: rtl/noc_pend_sb.sv
// Pending-request scoreboard: one bit per page id plus a count of
// outstanding requests. Lookups see the state at the start of the cycle.
module noc_pend_sb import noc_pkg::*; #(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_i,
  input  logic [PAGE_ID_W-1:0] set_id_i,
  input  logic                 clr_i,
  input  logic [PAGE_ID_W-1:0] clr_id_i,
  input  logic                 clr_all_i,
  input  logic [PAGE_ID_W-1:0] lk_a_id_i,
  output logic                 hit_a_o,
  input  logic [PAGE_ID_W-1:0] lk_b_id_i,
  output logic                 hit_b_o,
  output logic [CNT_W-1:0]     outstanding_o,
  output logic                 full_o
);
  logic [N_PAGES-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (clr_all_i) begin
      pend_d = '0;
      cnt_d  = '0;
    end else begin
      if (set_i) pend_d[set_id_i] = 1'b1;
      if (clr_i) pend_d[clr_id_i] = 1'b0;
      // a set and a clear in the same cycle leave the count unchanged
      if (set_i && !clr_i)      cnt_d = cnt_q + CNT_W'(1);
      else if (!set_i && clr_i) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign hit_a_o       = pend_q[lk_a_id_i];
  assign hit_b_o       = pend_q[lk_b_id_i];
  assign outstanding_o = cnt_q;
  assign full_o        = (cnt_q == CNT_W'(MAX_OUT));
endmodule

// File: rtl/noc_client.sv
// NoC client: walks a neighbour-id list, requests each distinct page from the
// network, sums the returned values, and serves its own page table to queries.
module noc_client import noc_pkg::*; #(
  parameter int DATA_W  = 16,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [6:0]                  count,
  output logic [PAGE_ID_W-1:0]        list_addr,
  input  logic [PAGE_ID_W-1:0]        list_id,
  noc_client_if.master                net,
  input  logic                        wr_en,
  input  logic [3:0]                  wr_idx,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        busy,
  output logic                        done,
  output logic [DATA_W+PAGE_ID_W-1:0] sum,
  output logic                        err_timeout,
  output logic                        err_unexp
);
  localparam int SUM_W = DATA_W + PAGE_ID_W;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [PAGE_ID_W-1:0] addr_q, addr_d;
  logic [6:0]           count_q, count_d;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic                 etmo_q, etmo_d, eunx_q, eunx_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [DATA_W-1:0]    page_q [TABLE_N];

  logic [PAGE_ID_W-1:0] rsp_id;
  logic [DATA_W-1:0]    rsp_val;
  logic                 id_pend, rsp_pend, sb_full;
  logic [CNT_W-1:0]     outstanding;
  logic                 issue, rsp_acc, sb_clr_all, active, last_entry, skip;

  assign rsp_id     = net.response[RESP_ID_MSB:RESP_ID_LSB];
  assign rsp_val    = net.response[SUM_W-1:RESP_VAL_LSB];
  assign active     = (state_q == S_LOAD) || (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign last_entry = ({1'b0, addr_q} == (count_q - 7'd1));
  assign skip       = (list_id == NO_REQ) || id_pend;

  noc_pend_sb #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) u_sb (
    .clk           (clk),
    .reset         (reset),
    .set_i         (issue),
    .set_id_i      (list_id),
    .clr_i         (rsp_acc),
    .clr_id_i      (rsp_id),
    .clr_all_i     (sb_clr_all),
    .lk_a_id_i     (list_id),
    .hit_a_o       (id_pend),
    .lk_b_id_i     (rsp_id),
    .hit_b_o       (rsp_pend),
    .outstanding_o (outstanding),
    .full_o        (sb_full)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    sum_d      = sum_q;
    etmo_d     = etmo_q;
    eunx_d     = eunx_q;
    tmo_d      = tmo_q;
    issue      = 1'b0;
    rsp_acc    = 1'b0;
    sb_clr_all = 1'b0;

    // responses outside a fetch are ignored so stale replies cannot flag errors
    if (active && net.response_valid) begin
      if (rsp_pend) begin
        rsp_acc = 1'b1;
        sum_d   = sum_q + SUM_W'(rsp_val);
      end else begin
        eunx_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d     = '0;
          count_d    = count;
          sum_d      = '0;
          etmo_d     = 1'b0;
          eunx_d     = 1'b0;
          tmo_d      = '0;
          sb_clr_all = 1'b1;
          state_d    = (count == 7'd0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD:  state_d = S_ISSUE;
      S_ISSUE: begin
        if (skip || !sb_full) begin
          issue = !skip;
          if (last_entry) begin
            state_d = S_WAIT;
          end else begin
            addr_d  = addr_q + 6'd1;
            state_d = S_LOAD;
          end
        end
      end
      S_WAIT: if (outstanding == '0) state_d = S_DONE;
      S_DONE: begin
        sb_clr_all = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_ISSUE) || (state_q == S_WAIT)) begin
      if (issue || rsp_acc) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        tmo_d   = '0;
        etmo_d  = 1'b1;
        state_d = S_DONE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      sum_q   <= '0;
      etmo_q  <= 1'b0;
      eunx_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      etmo_q  <= etmo_d;
      eunx_q  <= eunx_d;
      tmo_q   <= tmo_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TABLE_N; i++) page_q[i] <= '0;
    end else if (wr_en) begin
      page_q[wr_idx] <= wr_data;
    end
  end

  assign net.request = issue ? list_id : NO_REQ;
  assign net.reply   = page_q[net.query_id[3:0]];
  assign list_addr   = addr_q;
  assign busy        = active;
  assign done        = (state_q == S_DONE);
  assign sum         = sum_q;
  assign err_timeout = etmo_q;
  assign err_unexp   = eunx_q;
endmodule

// File: tb/tb_noc_client.sv
// Directed bench for noc_client: a page-table vector table plus hand-written
// fetch sequences against a default instance and a MAX_OUT=2/TIMEOUT=10 one.
module tb_noc_client;
  import noc_pkg::*;
  localparam int DW = 16;
  localparam int SW = DW + PAGE_ID_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start_a, start_b;
  logic [6:0]    count_a, count_b;
  logic [5:0]    addr_a, addr_b, lid_a, lid_b;
  logic          wr_en;
  logic [3:0]    wr_idx;
  logic [DW-1:0] wr_data;
  logic          busy_a, busy_b, done_a, done_b;
  logic [SW-1:0] sum_a, sum_b;
  logic          etmo_a, etmo_b, eunx_a, eunx_b;

  noc_client_if #(.DATA_W(DW)) ifa ();
  noc_client_if #(.DATA_W(DW)) ifb ();

  noc_client #(.DATA_W(DW)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .count(count_a),
    .list_addr(addr_a), .list_id(lid_a), .net(ifa),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .busy(busy_a), .done(done_a), .sum(sum_a),
    .err_timeout(etmo_a), .err_unexp(eunx_a)
  );

  noc_client #(.DATA_W(DW), .MAX_OUT(2), .TIMEOUT(10)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .count(count_b),
    .list_addr(addr_b), .list_id(lid_b), .net(ifb),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .busy(busy_b), .done(done_b), .sum(sum_b),
    .err_timeout(etmo_b), .err_unexp(eunx_b)
  );

  // neighbour list memory with one-cycle read latency
  logic [5:0]    mem  [64];
  logic [DW-1:0] vals [64];
  always @(posedge clk) begin
    lid_a <= mem[addr_a];
    lid_b <= mem[addr_b];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  int         n_req, done_cnt, done_cyc;
  logic [5:0] req_id  [16];
  int         req_cyc [16];
  logic [5:0] probe_req, probe_addr;
  logic       probe_busy;

  task automatic start_fetch(input bit sel, input logic [6:0] cnt);
    @(negedge clk);
    if (sel) begin start_b = 1'b1; count_b = cnt; end
    else     begin start_a = 1'b1; count_a = cnt; end
  endtask

  // Network model: answers each issued id at max(issue+delay, hold), in order,
  // never in the issue cycle; optionally injects one stray response.
  task automatic run(input bit sel, input int max_cyc, input int delay, input int hold,
                     input int stray_cyc, input logic [5:0] stray_id,
                     input logic [DW-1:0] stray_val, input int probe_cyc);
    int ptr;
    int due [16];
    logic [5:0] rq;
    logic dn, rv;
    logic [SW-1:0] rsp;
    n_req = 0; done_cnt = 0; done_cyc = -1; ptr = 0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      rq = sel ? ifb.request : ifa.request;
      dn = sel ? done_b : done_a;
      if (k == probe_cyc) begin
        probe_req  = rq;
        probe_addr = sel ? addr_b : addr_a;
        probe_busy = sel ? busy_b : busy_a;
      end
      if (rq != 6'd0 && n_req < 16) begin
        req_id[n_req]  = rq;
        req_cyc[n_req] = k;
        due[n_req]     = (k + delay > hold) ? k + delay : hold;
        n_req++;
      end
      if (dn) begin done_cnt++; done_cyc = k; end
      rv = 1'b0; rsp = '0;
      if (k == stray_cyc) begin
        rv = 1'b1; rsp = {stray_val, stray_id};
      end else if (ptr < n_req && due[ptr] <= k && req_cyc[ptr] < k) begin
        rv = 1'b1; rsp = {vals[req_id[ptr]], req_id[ptr]};
        ptr++;
      end
      if (sel) begin ifb.response_valid = rv; ifb.response = rsp; end
      else     begin ifa.response_valid = rv; ifa.response = rsp; end
      if (done_cnt > 0 && k >= done_cyc + 2) break;
    end
    @(negedge clk);
    ifa.response_valid = 1'b0;
    ifb.response_valid = 1'b0;
  endtask

  typedef struct {
    logic          we;
    logic [3:0]    idx;
    logic [DW-1:0] data;
    logic [5:0]    qid;
    logic [DW-1:0] pre;
    logic [DW-1:0] post;
  } pt_vec_t;
  pt_vec_t pv [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start_a = 1'b0; start_b = 1'b0; count_a = '0; count_b = '0;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    ifa.response_valid = 1'b0; ifa.response = '0; ifa.query_id = '0;
    ifb.response_valid = 1'b0; ifb.response = '0; ifb.query_id = '0;
    for (int i = 0; i < 64; i++) begin mem[i] = '0; vals[i] = '0; end

    pv[0] = '{1'b1, 4'd3,  16'h00AB, 6'd35, 16'h0000, 16'h00AB};
    pv[1] = '{1'b1, 4'd15, 16'h1234, 6'd15, 16'h0000, 16'h1234};
    pv[2] = '{1'b0, 4'd15, 16'hFFFF, 6'd63, 16'h1234, 16'h1234};
    pv[3] = '{1'b1, 4'd0,  16'hBEEF, 6'd19, 16'h00AB, 16'h00AB};
    pv[4] = '{1'b0, 4'd0,  16'h0000, 6'd16, 16'hBEEF, 16'hBEEF};
    pv[5] = '{1'b1, 4'd3,  16'h5555, 6'd3,  16'h00AB, 16'h5555};

    repeat (2) @(negedge clk);
    chk("rst_busy",  busy_a, 0);
    chk("rst_done",  done_a, 0);
    chk("rst_sum",   sum_a, 0);
    chk("rst_errs",  {etmo_a, eunx_a}, 0);
    chk("rst_req",   ifa.request, 0);
    chk("rst_addr",  addr_a, 0);
    chk("rst_reply", ifa.reply, 0);
    chk("rst_b_busy", busy_b, 0);
    @(negedge clk);
    reset = 1'b0;

    // page table write / combinational query
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      wr_en = pv[v].we; wr_idx = pv[v].idx; wr_data = pv[v].data; ifa.query_id = pv[v].qid;
      #1 chk($sformatf("pt_pre[%0d]", v), ifa.reply, pv[v].pre);
      @(posedge clk);
      #1 chk($sformatf("pt_post[%0d]", v), ifa.reply, pv[v].post);
    end
    @(negedge clk);
    wr_en = 1'b0;

    // unexpected response id 40
    mem[0] = 6'd12; vals[12] = 16'd3;
    start_fetch(1'b0, 7'd1);
    run(1'b0, 40, 6, 0, 3, 6'd40, 16'd100, -1);
    chk("unx_nreq", n_req, 1);
    chk("unx_id", req_id[0], 12);
    chk("unx_flag", eunx_a, 1);
    chk("unx_sum", sum_a, 3);
    chk("unx_done", done_cnt, 1);
    chk("unx_tmo", etmo_a, 0);

    // basic three-entry fetch, 4-cycle response latency
    mem[0] = 6'd20; mem[1] = 6'd21; mem[2] = 6'd22;
    vals[20] = 16'd5; vals[21] = 16'd6; vals[22] = 16'd7;
    start_fetch(1'b0, 7'd3);
    run(1'b0, 60, 4, 0, -1, 6'd0, 16'd0, -1);
    chk("basic_nreq", n_req, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("basic_id[%0d]", i), req_id[i], 20 + i);
      chk($sformatf("basic_cyc[%0d]", i), req_cyc[i], 1 + 2 * i);
    end
    chk("basic_sum", sum_a, 18);
    chk("basic_done", done_cnt, 1);
    chk("basic_errs", {etmo_a, eunx_a}, 0);
    repeat (3) @(negedge clk);
    chk("basic_sum_held", sum_a, 18);
    chk("basic_idle", busy_a, 0);

    // response in the same cycle as its own issue is unexpected
    mem[0] = 6'd12;
    start_fetch(1'b0, 7'd1);
    run(1'b0, 40, 6, 0, 1, 6'd12, 16'd50, -1);
    chk("same_nreq", n_req, 1);
    chk("same_flag", eunx_a, 1);
    chk("same_sum", sum_a, 3);
    chk("same_done", done_cnt, 1);

    // duplicate and zero entries skipped
    mem[0] = 6'd30; mem[1] = 6'd0; mem[2] = 6'd30; vals[30] = 16'd9;
    start_fetch(1'b0, 7'd3);
    run(1'b0, 60, 4, 0, -1, 6'd0, 16'd0, -1);
    chk("dup_nreq", n_req, 1);
    chk("dup_id", req_id[0], 30);
    chk("dup_sum", sum_a, 9);
    chk("dup_done", done_cnt, 1);
    chk("dup_unx", eunx_a, 0);

    // count = 0 finishes immediately
    start_fetch(1'b0, 7'd0);
    run(1'b0, 10, 4, 0, -1, 6'd0, 16'd0, -1);
    chk("zero_done", done_cnt, 1);
    chk("zero_done_cyc", done_cyc, 0);
    chk("zero_sum", sum_a, 0);
    chk("zero_nreq", n_req, 0);

    // MAX_OUT=2 stall, released by one response at cycle 10
    for (int i = 0; i < 4; i++) begin mem[i] = 6'(i + 1); vals[i + 1] = 16'(10 * (i + 1)); end
    start_fetch(1'b1, 7'd4);
    run(1'b1, 60, 1, 10, -1, 6'd0, 16'd0, 10);
    chk("stall_req", probe_req, 0);
    chk("stall_addr", probe_addr, 2);
    chk("stall_busy", probe_busy, 1);
    chk("stall_nreq", n_req, 4);
    chk("stall_third_cyc", req_cyc[2], 11);
    chk("stall_third_id", req_id[2], 3);
    chk("stall_sum", sum_b, 100);
    chk("stall_done", done_cnt, 1);
    chk("stall_errs", {etmo_b, eunx_b}, 0);

    // timeout with no responses (TIMEOUT=10)
    mem[0] = 6'd5; vals[5] = 16'd7;
    start_fetch(1'b1, 7'd1);
    run(1'b1, 40, 1000, 0, -1, 6'd0, 16'd0, -1);
    chk("tmo_nreq", n_req, 1);
    chk("tmo_done", done_cnt, 1);
    chk("tmo_gap", done_cyc - req_cyc[0], 11);
    chk("tmo_flag", etmo_b, 1);
    chk("tmo_sum", sum_b, 0);
    @(negedge clk);
    ifb.response_valid = 1'b1; ifb.response = {16'd7, 6'd5};
    @(negedge clk);
    ifb.response_valid = 1'b0;
    @(negedge clk);
    chk("tmo_late_idle", eunx_b, 0);
    chk("tmo_late_sum", sum_b, 0);

    // reset in the middle of a fetch
    mem[0] = 6'd20; mem[1] = 6'd21; mem[2] = 6'd22;
    start_fetch(1'b0, 7'd3);
    run(1'b0, 4, 1000, 0, -1, 6'd0, 16'd0, -1);
    chk("abort_pre_nreq", n_req, 2);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy_a, 0);
    chk("abort_req", ifa.request, 0);
    chk("abort_addr", addr_a, 0);
    chk("abort_done", done_a, 0);
    @(negedge clk);
    reset = 1'b0;
    ifa.response_valid = 1'b1; ifa.response = {16'd5, 6'd20};
    @(negedge clk);
    ifa.response_valid = 1'b0;
    @(negedge clk);
    chk("abort_late_idle", eunx_a, 0);
    chk("abort_sum", sum_a, 0);
    start_fetch(1'b0, 7'd1);
    run(1'b0, 40, 4, 0, 3, 6'd21, 16'd6, -1);
    chk("abort_late_unx", eunx_a, 1);
    chk("abort_new_sum", sum_a, 5);
    chk("abort_new_done", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/noc_client.md
NOC_CLIENT -- requirements
Module: noc_client

Interface
REQ-001 Parameter DATA_W, default 16, page-value width; SHALL match the network DATA_W.
REQ-002 Parameter MAX_OUT, default 4, maximum outstanding requests (1..8).
REQ-003 Parameter TIMEOUT, default 255, idle cycles without a response before abort.
REQ-004 clk  in  1  single clock, rising edge; only clock in the block.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; begins a fetch when idle; ignored when busy.
REQ-007 count  in  7  number of list entries to process, 0..64; sampled on start.
REQ-008 list_addr  out  6  read address into the node's neighbour-id list.
REQ-009 list_id  in  6  list entry at list_addr; valid one cycle after list_addr changes.
REQ-010 request  out  6  page id driven to the network request port; 0 = no request.
REQ-011 response  in  DATA_W+6  {value[DATA_W+5:6], page_id[5:0]} from the network.
REQ-012 response_valid  in  1  response carries a new reply this cycle.
REQ-013 query_id  in  6  page id the network asks this node for.
REQ-014 reply  out  DATA_W  local value for query_id.
REQ-015 wr_en, wr_idx, wr_data  in  1/4/DATA_W  write port into the local 16-entry page table.
REQ-016 busy  out  1  fetch in progress.
REQ-017 done  out  1  one-cycle pulse at the end of a fetch.
REQ-018 sum  out  DATA_W+6  accumulated response values; held until the next start.
REQ-019 err_timeout, err_unexp  out  1  sticky error flags; cleared on start.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, ISSUE, WAIT and DONE.
REQ-021 IDLE->LOAD on start: sum, errors and counters SHALL clear; list_addr SHALL be 0.
REQ-022 start with count=0 SHALL go IDLE->DONE directly and pulse done with sum=0.
REQ-023 LOAD SHALL take one cycle so that list_id becomes valid, then go to ISSUE.
REQ-024 ISSUE SHALL drive request=list_id for exactly one cycle only if list_id!=0, the id is not already pending, and outstanding<MAX_OUT; otherwise request SHALL be 0.
REQ-025 Entries with list_id==0, or whose id is already pending, SHALL be skipped: no request is issued and the entry is not counted as expected.
REQ-026 When outstanding==MAX_OUT, the FSM SHALL stall in ISSUE with request=0 and list_addr held.
REQ-027 After each issued or skipped entry, list_addr SHALL increment and the FSM SHALL return to LOAD; after entry count-1 the FSM SHALL go to WAIT.
REQ-028 A response_valid whose page_id is pending SHALL clear its pending bit, add value to sum with unsigned zero-extension and no wrap for up to 64 terms, and decrement outstanding.
REQ-029 A response_valid whose page_id is not pending SHALL be dropped and SHALL set err_unexp.
REQ-030 A response and an issue in the same cycle SHALL both take effect, with outstanding net unchanged.
REQ-031 Pending state SHALL be sampled at the start of the cycle; a response matching the id issued in that same cycle is unexpected.
REQ-032 WAIT->DONE SHALL occur when outstanding==0.
REQ-033 The timeout counter SHALL run in ISSUE and WAIT, reset on each accepted response, and on reaching TIMEOUT SHALL set err_timeout and go to DONE.
REQ-034 DONE SHALL pulse done for one cycle, clear all pending bits, then return to IDLE.
REQ-035 reply SHALL equal table[query_id[3:0]] combinationally.
REQ-036 A write to an entry SHALL be visible on reply in the cycle after wr_en.

Reset
REQ-037 Reset SHALL force state=IDLE, request=0, list_addr=0, busy=0, done=0, sum=0, both error flags 0, outstanding=0, all pending bits 0 and the timeout counter to 0.
REQ-038 Local page-table contents SHALL reset to 0.
REQ-039 Reset asserted mid-fetch SHALL abort the fetch without a done pulse; any late responses that follow SHALL set err_unexp only after a new start.

Structure
REQ-040 Shared package noc_pkg SHALL hold PAGE_ID_W=6, NO_REQ=6'd0, the response field offsets and the FSM state encoding.
REQ-041 A sub-module noc_pend_sb SHALL implement the 64-bit pending scoreboard with set, clear, clear-all and lookup, and an outstanding count.

Verification
REQ-042 count=3, ids {20,21,22}, responses value 5/6/7 after a 4-cycle delay -> requests 20,21,22 on alternate cycles; sum=18; one done pulse; no errors.
REQ-043 MAX_OUT=2, count=4, responses withheld -> exactly two requests, then request=0 and list_addr stalled; releasing one response triggers the third request.
REQ-044 ids {30,0,30} -> a single request for 30; one response of 9 -> sum=9, done asserted.
REQ-045 Response page_id=40 when not pending -> err_unexp=1 and sum unchanged.
REQ-046 TIMEOUT=10 with no responses -> err_timeout=1 and done exactly 10 idle cycles after the last issue.
REQ-047 wr table[3]=16'h00AB, query_id=35 -> reply=16'h00AB on the next cycle.
